// File: rtl/key_input_pkg.sv
// ---------------------------------------------------------------------------
// key_input_pkg
//   Shared definitions for the pushbutton front end: per-key debounce state
//   encoding and the default debounce timing for a 50 MHz board clock.
// ---------------------------------------------------------------------------
package key_input_pkg;

    typedef enum logic [1:0] {
        KS_RELEASED     = 2'd0,
        KS_PRESS_WAIT   = 2'd1,
        KS_PRESSED      = 2'd2,
        KS_RELEASE_WAIT = 2'd3
    } key_state_t;

    // 10 ms of stable samples at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_CNT_W           = 19;

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
//   One pushbutton: two-flop synchronizer, four-state debounce FSM and
//   stable-sample counter.
//   Ports:
//     Clock    in   system clock, rising edge
//     Reset_b  in   asynchronous active-low reset
//     key_n    in   raw button, 0 = pressed, asynchronous to Clock
//     held     out  debounced level, 1 = pressed
//     press    out  registered one-cycle pulse when a press is accepted
// ---------------------------------------------------------------------------
module key_debounce
    import key_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic Clock,
    input  logic Reset_b,
    input  logic key_n,
    output logic held,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    key_state_t       state;
    key_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             press_nxt;

    // Synchronizer: idles at 1 (released) so reset never looks like a press
    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= key_n;
            sync_p1 <= sync_p0;
        end
    end

    // State register, counter and press pulse register
    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            state <= KS_RELEASED;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            press <= press_nxt;
        end
    end

    // Next-state: any sample agreeing with the current debounced level
    // aborts a pending change (bounce).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            KS_RELEASED: begin
                if (!sync_p1) begin
                    state_nxt = KS_PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            KS_PRESS_WAIT: begin
                if (sync_p1)               state_nxt = KS_RELEASED;
                else if (cnt == CNT_LAST)  state_nxt = KS_PRESSED;
                else                       cnt_nxt   = cnt + CNT_W'(1);
            end
            KS_PRESSED: begin
                if (sync_p1) begin
                    state_nxt = KS_RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            KS_RELEASE_WAIT: begin
                if (!sync_p1)              state_nxt = KS_PRESSED;
                else if (cnt == CNT_LAST)  state_nxt = KS_RELEASED;
                else                       cnt_nxt   = cnt + CNT_W'(1);
            end
            default: begin
                state_nxt = KS_RELEASED;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs: held follows the state; press is armed only on the
    // PRESS_WAIT -> PRESSED transition, never on release.
    always_comb begin
        held      = (state == KS_PRESSED) || (state == KS_RELEASE_WAIT);
        press_nxt = (state == KS_PRESS_WAIT) && !sync_p1 && (cnt == CNT_LAST);
    end

endmodule

// File: rtl/key_input_ctrl.sv
// ---------------------------------------------------------------------------
// key_input_ctrl
//   Pushbutton front end: debounces NUM_KEYS active-low buttons and buffers
//   the highest-priority press as a code behind a valid/ready handshake.
//   Ports:
//     Clock       in   system clock, rising edge
//     Reset_b     in   asynchronous active-low reset
//     key_n       in   raw buttons, 0 = pressed
//     held        out  debounced levels, 1 = pressed
//     press       out  one-cycle pulse per accepted press
//     code        out  index of buffered press
//     code_valid  out  buffer holds an unconsumed press
//     code_ready  in   consumer takes code this cycle when code_valid=1
//     overflow    out  sticky: a press was dropped because the buffer was full
// ---------------------------------------------------------------------------
module key_input_ctrl
    import key_input_pkg::*;
#(
    parameter int  NUM_KEYS        = 4,
    parameter int  DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int  CNT_W           = DEFAULT_CNT_W,
    localparam int CODE_W          = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                Clock,
    input  logic                Reset_b,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] held,
    output logic [NUM_KEYS-1:0] press,
    output logic [CODE_W-1:0]   code,
    output logic                code_valid,
    input  logic                code_ready,
    output logic                overflow
);

    // Ascending scan so the highest set index is the one left in idx
    function automatic logic [CODE_W-1:0] highest_index(input logic [NUM_KEYS-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (v[i]) idx = CODE_W'(i);
        end
        return idx;
    endfunction

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_key (
            .Clock   (Clock),
            .Reset_b (Reset_b),
            .key_n   (key_n[g]),
            .held    (held[g]),
            .press   (press[g])
        );
    end

    logic any_press;
    logic consume;
    logic load;

    // A slot is free if empty or being drained in the same cycle
    always_comb begin
        any_press = |press;
        consume   = code_valid & code_ready;
        load      = any_press & (~code_valid | code_ready);
    end

    // Code buffer stage
    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            code       <= '0;
            code_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (load) begin
                code       <= highest_index(press);
                code_valid <= 1'b1;
            end else if (consume) begin
                code_valid <= 1'b0;
            end
            if (any_press & code_valid & ~code_ready) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_key_input_ctrl.sv
module tb_key_input_ctrl;

    localparam int NK = 4;
    localparam int DC = 4;

    logic       Clock;
    logic       Reset_b;
    logic [3:0] key_n;
    logic [3:0] held;
    logic [3:0] press;
    logic [1:0] code;
    logic       code_valid;
    logic       code_ready;
    logic       overflow;

    int checks;
    int failures;

    key_input_ctrl #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (3)
    ) dut (
        .Clock      (Clock),
        .Reset_b    (Reset_b),
        .key_n      (key_n),
        .held       (held),
        .press      (press),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .overflow   (overflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model: a level flips after DC+1 consecutive disagreeing
    // samples of the key delayed by two clocks.
    logic [3:0] m_d1, m_d2;
    logic [3:0] m_lvl;
    int         m_run [4];
    logic [3:0] m_press;
    logic       m_cv;
    logic [1:0] m_code;
    logic       m_ovf;

    task automatic model_reset();
        m_d1 = 4'hF; m_d2 = 4'hF; m_lvl = 4'h0;
        for (int k = 0; k < 4; k++) m_run[k] = 0;
        m_press = 4'h0; m_cv = 1'b0; m_code = 2'd0; m_ovf = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] kn, input logic rdy);
        logic [3:0] s;
        logic [3:0] pnew;
        s = m_d2; m_d2 = m_d1; m_d1 = kn;
        pnew = 4'h0;
        for (int k = 0; k < 4; k++) begin
            if (!s[k] != m_lvl[k]) begin
                m_run[k] = m_run[k] + 1;
                if (m_run[k] == DC + 1) begin
                    m_lvl[k] = ~m_lvl[k];
                    m_run[k] = 0;
                    if (m_lvl[k]) pnew[k] = 1'b1;
                end
            end else begin
                m_run[k] = 0;
            end
        end
        if (m_press != 4'h0) begin
            if (!m_cv || rdy) begin
                for (int k = 3; k >= 0; k--) begin
                    if (m_press[k]) begin
                        m_code = 2'(k);
                        break;
                    end
                end
                m_cv = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_cv && rdy) begin
            m_cv = 1'b0;
        end
        m_press = pnew;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_model();
        chk("model_held",  32'(held),       32'(m_lvl));
        chk("model_press", 32'(press),      32'(m_press));
        chk("model_valid", 32'(code_valid), 32'(m_cv));
        chk("model_code",  32'(code),       32'(m_code));
        chk("model_ovf",   32'(overflow),   32'(m_ovf));
    endtask

    task automatic tick(input logic [3:0] kn, input logic rdy);
        key_n = kn;
        code_ready = rdy;
        @(posedge Clock);
        model_step(kn, rdy);
        #1;
        chk_model();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_held"},  32'(held),       32'd0);
        chk({tag, "_press"}, 32'(press),      32'd0);
        chk({tag, "_valid"}, 32'(code_valid), 32'd0);
        chk({tag, "_code"},  32'(code),       32'd0);
        chk({tag, "_ovf"},   32'(overflow),   32'd0);
    endtask

    task automatic do_reset(input int n);
        Reset_b = 1'b0;
        model_reset();
        #1;
        chk_all_zero("reset");
        repeat (n) @(posedge Clock);
        #1;
        chk_all_zero("reset_hold");
        Reset_b = 1'b1;
    endtask

    task automatic settle(input logic rdy);
        repeat (12) tick(4'hF, rdy);
    endtask

    typedef struct {
        logic [3:0] kn;
        logic       rdy;
        logic [3:0] held;
        logic [3:0] press;
        logic       cv;
        logic [1:0] code;
        logic       ovf;
    } vec_t;

    vec_t tbl [17];

    initial begin
        int n_press;
        int at_edge;
        logic [3:0] lv;

        checks = 0;
        failures = 0;
        key_n = 4'hF;
        code_ready = 1'b0;
        Reset_b = 1'b0;
        model_reset();

        // key 2 pressed from edge 1, consumed at edge 10, released from edge 11
        for (int i = 0; i < 17; i++) begin
            tbl[i].kn    = (i < 10) ? 4'b1011 : 4'hF;
            tbl[i].rdy   = (i == 9);
            tbl[i].held  = (i >= 6 && i < 16) ? 4'b0100 : 4'h0;
            tbl[i].press = (i == 6) ? 4'b0100 : 4'h0;
            tbl[i].cv    = (i == 7 || i == 8);
            tbl[i].code  = (i >= 7) ? 2'd2 : 2'd0;
            tbl[i].ovf   = 1'b0;
        end

        // 1: reset and idle
        #2;
        do_reset(3);
        repeat (3) tick(4'hF, 1'b0);

        // 2: table-driven single press, handshake and release
        for (int i = 0; i < 17; i++) begin
            tick(tbl[i].kn, tbl[i].rdy);
            chk($sformatf("tbl%0d_held", i),  32'(held),       32'(tbl[i].held));
            chk($sformatf("tbl%0d_press", i), 32'(press),      32'(tbl[i].press));
            chk($sformatf("tbl%0d_valid", i), 32'(code_valid), 32'(tbl[i].cv));
            chk($sformatf("tbl%0d_code", i),  32'(code),       32'(tbl[i].code));
            chk($sformatf("tbl%0d_ovf", i),   32'(overflow),   32'(tbl[i].ovf));
        end
        settle(1'b1);

        // 3: bounce on key 1
        repeat (3) tick(4'b1101, 1'b1);
        tick(4'hF, 1'b1);
        n_press = 0; at_edge = 0;
        for (int j = 1; j <= 12; j++) begin
            tick(4'b1101, 1'b1);
            if (press[1]) begin
                n_press++;
                at_edge = j;
            end
        end
        chk("bounce_press_count", 32'(n_press), 32'd1);
        chk("bounce_press_edge",  32'(at_edge), 32'd7);
        settle(1'b1);

        // 5: simultaneous presses on keys 1 and 3
        repeat (7) tick(4'b0101, 1'b0);
        chk("simul_press", 32'(press), 32'b1010);
        tick(4'b0101, 1'b0);
        chk("simul_code",  32'(code),       32'd3);
        chk("simul_valid", 32'(code_valid), 32'd1);
        chk("simul_ovf",   32'(overflow),   32'd0);
        settle(1'b1);

        // 4: press while full -> overflow, code held, then drain
        repeat (8) tick(4'b1110, 1'b0);
        chk("hs_code0",  32'(code),       32'd0);
        chk("hs_valid0", 32'(code_valid), 32'd1);
        repeat (8) tick(4'b0110, 1'b0);
        chk("hs_ovf",   32'(overflow),   32'd1);
        chk("hs_code",  32'(code),       32'd0);
        chk("hs_valid", 32'(code_valid), 32'd1);
        tick(4'b0110, 1'b1);
        chk("hs_drain_valid", 32'(code_valid), 32'd0);
        chk("hs_drain_code",  32'(code),       32'd0);
        settle(1'b1);

        // 6: reset in the middle of PRESS_WAIT with key 0 held
        repeat (4) tick(4'b1110, 1'b1);
        do_reset(2);
        n_press = 0; at_edge = 0;
        for (int j = 1; j <= 14; j++) begin
            tick(4'b1110, 1'b1);
            if (press[0]) begin
                n_press++;
                at_edge = j;
            end
        end
        chk("rst_mid_press_count", 32'(n_press), 32'd1);
        chk("rst_mid_press_edge",  32'(at_edge), 32'd7);
        settle(1'b1);

        // Random bouncy keys and random ready against the model
        lv = 4'hF;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 9) == 0) lv[k] = ~lv[k];
            end
            tick(lv, 1'($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
